// File: rtl/ring_buff_mc_if.sv
// Bus bundle for ring_buff_mc: channel-addressed write/read requests in,
// registered read data, per-channel status and sticky errors out.
interface ring_buff_mc_if #(
  parameter int  NUM_CH    = 4,
  parameter int  DEPTH_CH  = 16,
  parameter type TYPE_FWRD = logic [15:0]
);
  localparam int WIDTH_CH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WIDTH_DEPTH = $clog2(DEPTH_CH);

  logic                                I_We;
  logic [WIDTH_CH-1:0]                 I_WCh;
  TYPE_FWRD                            I_FTk;
  logic                                I_Re;
  logic [WIDTH_CH-1:0]                 I_RCh;
  TYPE_FWRD                            O_FTk;
  logic                                O_Valid;
  logic [NUM_CH-1:0]                   O_Full;
  logic [NUM_CH-1:0]                   O_Empty;
  logic [NUM_CH-1:0]                   O_AFull;
  logic [NUM_CH*(WIDTH_DEPTH+1)-1:0]   O_Num;
  logic [1:0]                          O_Err;

  modport master (
    output I_We, I_WCh, I_FTk, I_Re, I_RCh,
    input  O_FTk, O_Valid, O_Full, O_Empty, O_AFull, O_Num, O_Err
  );

  modport slave (
    input  I_We, I_WCh, I_FTk, I_Re, I_RCh,
    output O_FTk, O_Valid, O_Full, O_Empty, O_AFull, O_Num, O_Err
  );
endinterface

// File: rtl/ring_buff_mc.sv
// Multi-channel ring buffer: NUM_CH independent FIFOs in one partitioned array,
// registered read port, per-channel almost-full with hysteresis, sticky errors.
module ring_buff_mc_ch #(
  parameter int DEPTH_CH = 16,
  parameter int AFULL_HI = DEPTH_CH - 2,
  parameter int AFULL_LO = DEPTH_CH / 2,
  parameter int WD       = $clog2(DEPTH_CH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  output logic [WD-1:0] waddr,
  output logic [WD-1:0] raddr,
  output logic [WD:0]   count,
  output logic          afull
);
  always_ff @(posedge clock) begin
    if (reset) begin
      waddr <= '0;
      raddr <= '0;
      count <= '0;
      afull <= 1'b0;
    end else begin
      if (wr) waddr <= waddr + 1'b1;
      if (rd) raddr <= raddr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Hysteresis on the pre-cycle count; set wins when both thresholds hit.
      if (count >= (WD+1)'(AFULL_HI))     afull <= 1'b1;
      else if (count < (WD+1)'(AFULL_LO)) afull <= 1'b0;
    end
  end
endmodule

module ring_buff_mc #(
  parameter int  NUM_CH    = 4,
  parameter int  DEPTH_CH  = 16,
  parameter type TYPE_FWRD = logic [15:0],
  parameter int  AFULL_HI  = DEPTH_CH - 2,
  parameter int  AFULL_LO  = DEPTH_CH / 2
) (
  input  logic           clock,
  input  logic           reset,
  ring_buff_mc_if.slave  bus
);
  localparam int WIDTH_CH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WIDTH_DEPTH = $clog2(DEPTH_CH);
  localparam int WN          = WIDTH_DEPTH + 1;

  logic [NUM_CH-1:0][WIDTH_DEPTH-1:0] waddr, raddr;
  logic [NUM_CH-1:0][WN-1:0]          cnt;
  logic [NUM_CH-1:0]                  full, empty, afull, wr, rd;
  logic                               wfull_sel, rempty_sel, we_ok, re_ok;
  logic [WIDTH_DEPTH-1:0]             wa_sel, ra_sel;

  TYPE_FWRD                           mem [NUM_CH*DEPTH_CH];
  TYPE_FWRD                           ftk_q;
  logic                               valid_q;
  logic [1:0]                         err_q;

  // An unmapped channel number behaves as full and empty, so it is rejected.
  always_comb begin
    wfull_sel  = 1'b1;
    rempty_sel = 1'b1;
    wa_sel     = '0;
    ra_sel     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.I_WCh == WIDTH_CH'(c)) begin
        wfull_sel = full[c];
        wa_sel    = waddr[c];
      end
      if (bus.I_RCh == WIDTH_CH'(c)) begin
        rempty_sel = empty[c];
        ra_sel     = raddr[c];
      end
    end
  end

  assign we_ok = bus.I_We & ~wfull_sel;
  assign re_ok = bus.I_Re & ~rempty_sel;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign full[c]  = (cnt[c] == WN'(DEPTH_CH));
    assign empty[c] = (cnt[c] == '0);
    assign wr[c]    = we_ok & (bus.I_WCh == WIDTH_CH'(c));
    assign rd[c]    = re_ok & (bus.I_RCh == WIDTH_CH'(c));

    ring_buff_mc_ch #(
      .DEPTH_CH (DEPTH_CH),
      .AFULL_HI (AFULL_HI),
      .AFULL_LO (AFULL_LO),
      .WD       (WIDTH_DEPTH)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .wr    (wr[c]),
      .rd    (rd[c]),
      .waddr (waddr[c]),
      .raddr (raddr[c]),
      .count (cnt[c]),
      .afull (afull[c])
    );
  end

  // Slot index {ch, addr} equals ch*DEPTH_CH + addr since DEPTH_CH is 2^n.
  always_ff @(posedge clock) begin
    if (!reset && we_ok) mem[{bus.I_WCh, wa_sel}] <= bus.I_FTk;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ftk_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      valid_q <= re_ok;
      ftk_q   <= re_ok ? mem[{bus.I_RCh, ra_sel}] : '0;
      err_q   <= err_q | {bus.I_Re & rempty_sel, bus.I_We & wfull_sel};
    end
  end

  assign bus.O_FTk   = ftk_q;
  assign bus.O_Valid = valid_q;
  assign bus.O_Full  = full;
  assign bus.O_Empty = empty;
  assign bus.O_AFull = afull;
  assign bus.O_Num   = cnt;
  assign bus.O_Err   = err_q;
endmodule

// File: tb/tb_ring_buff_mc.sv
// Directed + random checks of ring_buff_mc against a queue-per-channel model.
module tb_ring_buff_mc;
  localparam int NUM_CH = 4, DEPTH_CH = 16, WD = 4, WC = 2, HI = 14, LO = 8;
  typedef logic [15:0] tok_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ring_buff_mc_if #(.NUM_CH(NUM_CH), .DEPTH_CH(DEPTH_CH), .TYPE_FWRD(tok_t)) bus ();

  ring_buff_mc #(.NUM_CH(NUM_CH), .DEPTH_CH(DEPTH_CH), .TYPE_FWRD(tok_t),
                 .AFULL_HI(HI), .AFULL_LO(LO))
    dut (.clock(clock), .reset(reset), .bus(bus));

  tok_t              q [NUM_CH][$];
  logic [NUM_CH-1:0] m_afull;
  logic              m_valid;
  tok_t              m_tok;
  logic [1:0]        m_err;
  int                n_cmp = 0;
  int                n_bad = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [NUM_CH-1:0]          ef, ee;
    logic [NUM_CH*(WD+1)-1:0]   en;
    for (int c = 0; c < NUM_CH; c++) begin
      ef[c] = (q[c].size() == DEPTH_CH);
      ee[c] = (q[c].size() == 0);
      en[c*(WD+1) +: WD+1] = (WD+1)'(q[c].size());
    end
    chk({tag, ".valid"}, 64'(bus.O_Valid), 64'(m_valid));
    chk({tag, ".ftk"},   64'(bus.O_FTk),   64'(m_tok));
    chk({tag, ".full"},  64'(bus.O_Full),  64'(ef));
    chk({tag, ".empty"}, 64'(bus.O_Empty), 64'(ee));
    chk({tag, ".afull"}, 64'(bus.O_AFull), 64'(m_afull));
    chk({tag, ".num"},   64'(bus.O_Num),   64'(en));
    chk({tag, ".err"},   64'(bus.O_Err),   64'(m_err));
  endtask

  task automatic drive(bit we, int wch, tok_t d, bit re, int rch);
    bus.I_We  = we;
    bus.I_WCh = WC'(wch);
    bus.I_FTk = d;
    bus.I_Re  = re;
    bus.I_RCh = WC'(rch);
  endtask

  task automatic cyc(string tag, bit we, int wch, tok_t d, bit re, int rch);
    bit fpre, epre;
    @(negedge clock);
    drive(we, wch, d, re, rch);
    @(posedge clock);
    #1;
    fpre = (q[wch].size() == DEPTH_CH);
    epre = (q[rch].size() == 0);
    for (int c = 0; c < NUM_CH; c++) begin
      if (q[c].size() >= HI)     m_afull[c] = 1'b1;
      else if (q[c].size() < LO) m_afull[c] = 1'b0;
    end
    m_valid = 1'b0;
    m_tok   = '0;
    if (re) begin
      if (epre) m_err[1] = 1'b1;
      else begin
        m_valid = 1'b1;
        m_tok   = q[rch].pop_front();
      end
    end
    if (we) begin
      if (fpre) m_err[0] = 1'b1;
      else      q[wch].push_back(d);
    end
    check_all(tag);
  endtask

  task automatic do_reset(string tag, bit we, int ch, tok_t d, bit re);
    @(negedge clock);
    reset = 1'b1;
    drive(we, ch, d, re, ch);
    @(posedge clock);
    #1;
    for (int c = 0; c < NUM_CH; c++) q[c].delete();
    m_afull = '0;
    m_valid = 1'b0;
    m_tok   = '0;
    m_err   = 2'b00;
    check_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    drive(0, 0, '0, 0, 0);
    do_reset("rst0", 0, 0, '0, 0);
    do_reset("rst1", 1, 1, 16'hdead, 1);
    chk("rst.empty_all", 64'(bus.O_Empty), 64'hf);
    cyc("idle", 0, 0, '0, 0, 0);

    // FIFO order on one channel
    cyc("c2.w0", 1, 2, 16'h11, 0, 0);
    cyc("c2.w1", 1, 2, 16'h22, 0, 0);
    cyc("c2.w2", 1, 2, 16'h33, 0, 0);
    chk("c2.num3", 64'(bus.O_Num[2*(WD+1) +: WD+1]), 64'd3);
    cyc("c2.r0", 0, 0, '0, 1, 2);
    chk("c2.tok0", 64'(bus.O_FTk), 64'h11);
    cyc("c2.r1", 0, 0, '0, 1, 2);
    chk("c2.tok1", 64'(bus.O_FTk), 64'h22);
    cyc("c2.r2", 0, 0, '0, 1, 2);
    chk("c2.tok2", 64'(bus.O_FTk), 64'h33);
    chk("c2.empty", 64'(bus.O_Empty), 64'hf);

    // Fill, overflow, drain, refill with wrap
    for (int i = 0; i < DEPTH_CH; i++) cyc("c0.fill", 1, 0, tok_t'(16'h100 + i), 0, 0);
    cyc("c0.ovf", 1, 0, 16'h1ff, 0, 0);
    chk("c0.full", 64'(bus.O_Full[0]), 64'd1);
    chk("c0.err0", 64'(bus.O_Err[0]), 64'd1);
    for (int i = 0; i < DEPTH_CH; i++) cyc("c0.drain", 0, 0, '0, 1, 0);
    chk("c0.last", 64'(bus.O_FTk), 64'h10f);
    for (int i = 0; i < 5; i++) cyc("c0.refill", 1, 0, tok_t'(16'h200 + i), 0, 0);
    for (int i = 0; i < 5; i++) cyc("c0.redrain", 0, 0, '0, 1, 0);
    chk("c0.wrap", 64'(bus.O_FTk), 64'h204);

    // Almost-full hysteresis on ch1
    for (int i = 0; i < HI; i++) cyc("c1.fill", 1, 1, tok_t'(16'h300 + i), 0, 0);
    chk("c1.af_lag", 64'(bus.O_AFull[1]), 64'd0);
    cyc("c1.af_rise", 0, 0, '0, 0, 0);
    chk("c1.af_set", 64'(bus.O_AFull[1]), 64'd1);
    for (int i = 0; i < 5; i++) cyc("c1.dn9", 0, 0, '0, 1, 1);
    chk("c1.af_hold9", 64'(bus.O_AFull[1]), 64'd1);
    for (int i = 0; i < 2; i++) cyc("c1.dn7", 0, 0, '0, 1, 1);
    chk("c1.af_hold7", 64'(bus.O_AFull[1]), 64'd1);
    cyc("c1.af_fall", 0, 0, '0, 0, 0);
    chk("c1.af_clr", 64'(bus.O_AFull[1]), 64'd0);

    // Same-channel write+read: empty, then mid-occupancy
    cyc("c3.pair_empty", 1, 3, 16'h3a, 1, 3);
    chk("c3.udf_valid", 64'(bus.O_Valid), 64'd0);
    chk("c3.err1", 64'(bus.O_Err[1]), 64'd1);
    for (int i = 0; i < 4; i++) cyc("c3.fill", 1, 3, tok_t'(16'h3b + i), 0, 0);
    cyc("c3.pair5", 1, 3, 16'h3f, 1, 3);
    chk("c3.oldest", 64'(bus.O_FTk), 64'h3a);
    chk("c3.num5", 64'(bus.O_Num[3*(WD+1) +: WD+1]), 64'd5);

    // Reset mid-burst, then no stale data
    for (int i = 0; i < 8; i++) cyc("c0.burst", 1, 0, tok_t'(16'h400 + i), 0, 0);
    do_reset("midrst", 1, 0, 16'h555, 1);
    chk("midrst.num", 64'(bus.O_Num), 64'd0);
    cyc("c0.new_w", 1, 0, 16'hab, 0, 0);
    cyc("c0.new_r", 0, 0, '0, 1, 0);
    chk("c0.new_tok", 64'(bus.O_FTk), 64'hab);

    // Random traffic, write-heavy on low channels so full/afull get exercised
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rnd.rst", $urandom_range(0, 1), $urandom_range(0, 3), tok_t'($urandom), 1);
      else cyc("rnd", ($urandom_range(0, 3) != 0), $urandom_range(0, 3) & $urandom_range(0, 3),
               tok_t'($urandom), ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ring_buff_mc.md
Name: ring_buff_mc

Overview:
Multi-channel successor to the single-ring common buffer. It holds NUM_CH independent ring FIFOs, each DEPTH_CH entries deep, in one partitioned storage array. Each cycle it accepts one channel-addressed write and one channel-addressed read. It adds a registered read port, a per-channel almost-full flag with hysteresis for upstream back-pressure, and sticky overflow/underflow error flags. It sits between a token producer (router or link) and a consumer that needs per-channel buffering of forward tokens.

Parameters:
NUM_CH, 4, number of independent channels (>=1).
DEPTH_CH, 16, entries per channel (power of two, >=2).
WIDTH_CH, $clog2(NUM_CH) (min 1), channel-select width.
WIDTH_DEPTH, $clog2(DEPTH_CH), per-channel address width.
TYPE_FWRD, FTk_t, stored token type.
AFULL_HI, DEPTH_CH-2, occupancy at or above which O_AFull asserts.
AFULL_LO, DEPTH_CH/2, occupancy below which O_AFull deasserts (AFULL_LO <= AFULL_HI required).

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
I_We  in  1  write enable
I_WCh  in  WIDTH_CH  write channel select
I_FTk  in  TYPE_FWRD  write data
I_Re  in  1  read enable
I_RCh  in  WIDTH_CH  read channel select
O_FTk  out  TYPE_FWRD  read data, registered
O_Valid  out  1  O_FTk holds a valid token
O_Full  out  NUM_CH  per-channel full
O_Empty  out  NUM_CH  per-channel empty
O_AFull  out  NUM_CH  per-channel almost-full with hysteresis
O_Num  out  NUM_CH*(WIDTH_DEPTH+1)  per-channel occupancy; channel c in bits [c*(WIDTH_DEPTH+1) +: WIDTH_DEPTH+1]
O_Err  out  2  sticky {underflow, overflow}

Behaviour:
- Reset (synchronous, active-high): all pointers and counts go to 0. O_Empty = all 1s. O_Full, O_AFull, O_Valid, O_FTk, O_Err and O_Num all go to 0. Storage contents are not cleared; only the pointers are reset.
- Reset dominates any concurrent I_We/I_Re. An operation issued in the reset cycle has no effect.
- Storage: flat array of NUM_CH*DEPTH_CH entries. Channel c, slot s is at index c*DEPTH_CH + s.
- Each channel has its own WAddr, RAddr (WIDTH_DEPTH bits) and count (WIDTH_DEPTH+1 bits). Pointers wrap from DEPTH_CH-1 to 0 naturally.
- Full[c] = (count == DEPTH_CH). Empty[c] = (count == 0). Both are driven combinationally from the registered count.
- Accepted write: I_We & !Full[I_WCh]. The token is stored at WAddr, WAddr increments, and count increments.
- Write to a full channel: dropped. Storage and pointers are unchanged, and O_Err[0] is set.
- Accepted read: I_Re & !Empty[I_RCh]. Next cycle O_FTk = the token at RAddr and O_Valid = 1; RAddr increments and count decrements.
- Read from an empty channel: next cycle O_Valid = 0 and O_FTk = '0; O_Err[1] is set.
- A cycle with no read gives O_Valid = 0 and O_FTk = '0 in the following cycle.
- Read latency is exactly 1 cycle. There is no stall input; the consumer must accept O_FTk in the cycle O_Valid is high.
- Write and read to the same channel in the same cycle:
  - If the channel is neither empty nor full, both are accepted and count is unchanged.
  - If the channel is empty, the write is accepted, the read fails as an underflow, and there is no bypass.
  - If the channel is full, the read is accepted and the write is dropped as an overflow. Full is evaluated on the pre-cycle count.
- Write and read to different channels in the same cycle are fully independent.
- O_AFull[c] is registered:
  - It sets on the cycle after count >= AFULL_HI.
  - It clears on the cycle after count < AFULL_LO.
  - Otherwise it holds its value.
  - Set has priority if both conditions hold at once.
- O_Err bits are sticky until reset.
- O_Num reflects the registered counts with no lag relative to Full/Empty.

Test Plan:
- Reset, then idle: O_Empty=4'b1111, O_Num all 0, O_Valid=0, O_Err=2'b00.
- Write 0x11, 0x22, 0x33 to ch2, then read ch2 three times: O_Valid=1 with 0x11, 0x22, 0x33 on the cycles after each read; O_Empty[2] returns to 1; other channels untouched.
- Fill ch0 with 16 writes, then write a 17th: O_Full[0]=1, the 17th token is dropped, O_Err[0]=1. Reading 16 times returns the first 16 tokens in order, which checks pointer wrap after a further refill.
- Hysteresis on ch1: O_AFull[1] rises the cycle after count reaches 14. Reading down to 9 keeps it 1; reading down to 7 clears it the next cycle.
- Simultaneous write ch3 and read ch3 while ch3 is empty: count becomes 1, O_Valid=0, O_Err[1]=1. Repeat the pair with count=5: count stays 5 and the read data is the oldest token.
- Assert reset mid-burst with ch0 at count 8: next cycle all counts are 0, O_Valid=0, O_Err=0. A following write/read to ch0 returns the new token, not stale data.
